// File: rtl/reset_seq_pkg.sv
// Shared types and cause codes for the staged reset sequencer.
// Imported by reset_sequencer and its testbench.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_RST  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  // Lock loss outranks a soft request when both arrive together.
  function automatic logic [1:0] event_cause(input logic lock_loss);
    if (lock_loss) begin
      return CAUSE_LOCK;
    end else begin
      return CAUSE_SOFT;
    end
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Consecutive-count qualifier: ok goes high once `in` has been high for
// LOCK_FILT back-to-back cycles; a single low cycle or clr restarts it.
module lock_filter #(
  parameter int LOCK_FILT = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic ok
);

  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(LOCK_FILT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating run-length count of high samples.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !in) begin
      cnt_d = '0;
    end else if (cnt_q >= FILT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ok = (cnt_q >= FILT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain staged reset release: hold, wait for a qualified PLL lock,
// then drop stage_rst[0..N-1] one by one; re-sequences on soft request or lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int LOCK_FILT   = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  input  logic                lock_ok,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                seq_done,
  output logic                busy,
  output logic [1:0]          rst_cause
);

  localparam int               REL_W      = $clog2(N_STAGES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [REL_W-1:0] LAST_STAGE = REL_W'(N_STAGES - 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                seq_done_q, seq_done_d;
  logic                busy_q, busy_d;
  logic [1:0]          cause_q, cause_d;
  logic                lock_qual;
  logic                lock_loss;
  logic                filt_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + 1'b1;
    end
  endfunction

  // Lock dropping only matters once stages have started to release.
  assign lock_loss = !lock_ok && ((state_q == RELEASE) || (state_q == RUN));
  assign filt_clr  = (state_q != WAIT_LOCK) || soft_rst_req;

  lock_filter #(
    .LOCK_FILT (LOCK_FILT),
    .CNT_W     (CNT_W)
  ) u_lock_filter (
    .clk (clk),
    .rst (rst),
    .clr (filt_clr),
    .in  (lock_ok),
    .ok  (lock_qual)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rel_d       = rel_q;
    stage_rst_d = stage_rst_q;
    seq_done_d  = seq_done_q;
    cause_d     = cause_q;

    if (lock_loss || soft_rst_req) begin
      state_d     = HOLD;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      rel_d       = '0;
      stage_rst_d = '1;
      seq_done_d  = 1'b0;
      cause_d     = event_cause(lock_loss);
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q >= HOLD_LAST) begin
            state_d    = WAIT_LOCK;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = sat_inc(hold_cnt_q);
          end
        end
        WAIT_LOCK: begin
          if (lock_qual) begin
            stage_rst_d[0] = 1'b0;
            rel_d          = REL_W'(1);
            gap_cnt_d      = '0;
            if (N_STAGES == 1) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        RELEASE: begin
          if (gap_cnt_q >= GAP_LAST) begin
            // rel_q indexes the next stage still held in reset.
            for (int k = 0; k < N_STAGES; k++) begin
              stage_rst_d[k] = (rel_q == REL_W'(k)) ? 1'b0 : stage_rst_q[k];
            end
            rel_d     = rel_q + 1'b1;
            gap_cnt_d = '0;
            if (rel_q == LAST_STAGE) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            gap_cnt_d = sat_inc(gap_cnt_q);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d     = HOLD;
          hold_cnt_d  = '0;
          gap_cnt_d   = '0;
          rel_d       = '0;
          stage_rst_d = '1;
          seq_done_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != RUN);
  end

  // State and output registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rel_q       <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
      busy_q      <= 1'b1;
      cause_q     <= CAUSE_RST;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rel_q       <= rel_d;
      stage_rst_q <= stage_rst_d;
      seq_done_q  <= seq_done_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
    end
  end

  assign stage_rst = stage_rst_q;
  assign seq_done  = seq_done_q;
  assign busy      = busy_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: fixed-vector table, a bounded-wait latency check,
// and random stimulus against a timestamp-based reference model.
module tb_reset_sequencer;

  localparam int N     = 3;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int LF    = 4;
  localparam int MAX_E = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic         lock_ok = 1'b0;
  logic [N-1:0] stage_rst;
  logic         seq_done;
  logic         busy;
  logic [1:0]   rst_cause;

  int checks = 0;
  int failures = 0;

  reset_sequencer #(
    .N_STAGES(N), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .LOCK_FILT(LF), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .lock_ok(lock_ok),
    .stage_rst(stage_rst), .seq_done(seq_done), .busy(busy), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  // Reference model: sequence start edge, first-release edge, lock history.
  int  edge_n = 0;
  int  m_start = 0;
  int  m_r0 = -1;
  int  m_cause = 1;
  bit  lh [MAX_E];

  task automatic model_edge(input int e, input bit r, input bit s, input bit l);
    bit ok;
    if (e < MAX_E) lh[e] = l;
    if (r) begin
      m_cause = 1; m_start = e + 1; m_r0 = -1;
    end else if (m_r0 >= 0 && e > m_r0 && !l) begin
      m_cause = 3; m_start = e + 1; m_r0 = -1;
    end else if (s) begin
      m_cause = 2; m_start = e + 1; m_r0 = -1;
    end else if (m_r0 < 0 && (e - LF) >= (m_start + HOLD)) begin
      ok = 1'b1;
      for (int i = 1; i <= LF; i++) if (!lh[e - i]) ok = 1'b0;
      if (ok) m_r0 = e;
    end
  endtask

  function automatic logic [6:0] model_out(input int e);
    logic [N-1:0] st;
    logic done;
    for (int k = 0; k < N; k++) st[k] = !(m_r0 >= 0 && e >= m_r0 + k * GAP);
    done = (m_r0 >= 0 && e >= m_r0 + (N - 1) * GAP);
    return {st, done, !done, 2'(m_cause)};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {stage_rst, seq_done, busy, rst_cause};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got stage=%b done=%b busy=%b cause=%b want stage=%b done=%b busy=%b cause=%b",
               name, edge_n, got[6:4], got[3], got[2], got[1:0], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit l);
    rst = r; soft_rst_req = s; lock_ok = l;
    @(posedge clk);
    model_edge(edge_n, r, s, l);
    #1;
    check("model", model_out(edge_n));
    edge_n++;
  endtask

  typedef struct {
    int         n;
    bit         r;
    bit         s;
    bit         l;
    logic [2:0] st;
    logic       done;
    logic       bsy;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl [$];
  int   got_cyc;
  int   burst;
  bit   rr, ss, ll;

  initial begin
    // Power-up
    tbl.push_back('{5, 1, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{20, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{7, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{7, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b000, 1'b1, 1'b0, 2'b01});
    tbl.push_back('{3, 0, 0, 1, 3'b000, 1'b1, 1'b0, 2'b01});
    // Soft pulse in RUN
    tbl.push_back('{1, 0, 1, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{20, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{7, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{7, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1, 0, 0, 1, 3'b000, 1'b1, 1'b0, 2'b10});
    // Simultaneous soft + lock loss, then rst mid-sequence
    tbl.push_back('{1, 0, 1, 0, 3'b111, 1'b0, 1'b1, 2'b11});
    tbl.push_back('{25, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b11});
    tbl.push_back('{1, 1, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    // Late lock
    tbl.push_back('{1, 1, 0, 0, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{30, 0, 0, 0, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{4, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{15, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b000, 1'b1, 1'b0, 2'b01});
    // Lock glitch while waiting
    tbl.push_back('{2, 1, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{16, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{3, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 0, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{4, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b01});
    // Lock loss mid-release, stage 2 never released
    tbl.push_back('{8, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b01});
    tbl.push_back('{1, 0, 0, 0, 3'b111, 1'b0, 1'b1, 2'b11});
    tbl.push_back('{36, 0, 0, 1, 3'b100, 1'b0, 1'b1, 2'b11});
    tbl.push_back('{1, 0, 0, 1, 3'b000, 1'b1, 1'b0, 2'b11});
    // lock_ok low in HOLD / WAIT_LOCK is not an event
    tbl.push_back('{1, 0, 1, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{18, 0, 0, 0, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{4, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b10});
    // Soft request held high
    tbl.push_back('{40, 0, 1, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{20, 0, 0, 1, 3'b111, 1'b0, 1'b1, 2'b10});
    tbl.push_back('{1, 0, 0, 1, 3'b110, 1'b0, 1'b1, 2'b10});

    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(tbl[i].r, tbl[i].s, tbl[i].l);
      check($sformatf("vec%0d", i), {tbl[i].st, tbl[i].done, tbl[i].bsy, tbl[i].cause});
    end

    // Bounded wait for first release after reset
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    got_cyc = -1;
    for (int i = 0; i < 100 && got_cyc < 0; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (stage_rst[0] == 1'b0) got_cyc = i;
    end
    checks++;
    if (got_cyc != HOLD + LF) begin
      failures++;
      $display("FAIL first_release_cycle got=%0d want=%0d", got_cyc, HOLD + LF);
    end

    // Random stimulus against the reference model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      ss = ($urandom_range(0, 149) == 0);
      if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(1, 40);
      if (burst > 0) begin
        ll = 1'b0;
        burst--;
      end else begin
        ll = ($urandom_range(0, 59) != 0);
      end
      step(rr, ss, ll);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
